// File: rtl/matrix_mult_matrix_seq.sv
//------------------------------------------------------------------------------
// Module      : matrix_mult_matrix_seq
// Description : Sequential M x K by K x N unsigned matrix multiplier built on a
//               single shared MAC, with wrap/saturate and accumulate modes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module matrix_mult_matrix_seq #(
  parameter int FIRST_MATRIX_HEIGHT = 2,
  parameter int BOTH_MATRIX_W_H     = 2,
  parameter int SECOND_MATRIX_WIDTH = 2,
  parameter int DATA_WIDTH          = 8
) (
  input  logic                                                    clk,
  input  logic                                                    i_rst_n,
  input  logic                                                    i_calc,
  input  logic [1:0]                                              i_mode,
  input  logic [FIRST_MATRIX_HEIGHT*BOTH_MATRIX_W_H*DATA_WIDTH-1:0]     i_matrix_1,
  input  logic [BOTH_MATRIX_W_H*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0]     i_matrix_2,
  output logic [FIRST_MATRIX_HEIGHT*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0] o_result,
  output logic                                                    o_ready,
  output logic                                                    o_busy,
  output logic                                                    o_overflow
);

  localparam int c_m     = FIRST_MATRIX_HEIGHT;
  localparam int c_k     = BOTH_MATRIX_W_H;
  localparam int c_n     = SECOND_MATRIX_WIDTH;
  localparam int c_dw    = DATA_WIDTH;
  localparam int c_pw    = 2 * c_dw;
  // Wide enough that K full-scale products never overflow the accumulator.
  localparam int c_acc_w = 2 * c_dw + $clog2(c_k) + 1;
  localparam int c_v_w   = c_acc_w + 1;
  localparam int c_rw    = (c_m > 1) ? $clog2(c_m) : 1;
  localparam int c_kw    = (c_k > 1) ? $clog2(c_k) : 1;
  localparam int c_cw    = (c_n > 1) ? $clog2(c_n) : 1;

  localparam logic [c_rw-1:0] c_r_last = c_rw'(c_m - 1);
  localparam logic [c_kw-1:0] c_k_last = c_kw'(c_k - 1);
  localparam logic [c_cw-1:0] c_c_last = c_cw'(c_n - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MAC  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_m*c_k*c_dw-1:0] r_a;
  logic [c_k*c_n*c_dw-1:0] r_b;
  logic [c_m*c_n*c_dw-1:0] r_result;
  logic [1:0]              r_mode;
  logic [c_rw-1:0]         r_row;
  logic [c_cw-1:0]         r_col;
  logic [c_kw-1:0]         r_k;
  logic [c_acc_w-1:0]      r_acc;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_ovf;

  logic                    w_accept;
  logic                    w_step;
  logic                    w_elem_done;
  logic                    w_last;
  int                      w_a_idx;
  int                      w_b_idx;
  int                      w_c_idx;
  logic [c_dw-1:0]         w_a_elem;
  logic [c_dw-1:0]         w_b_elem;
  logic [c_pw-1:0]         w_prod;
  logic [c_acc_w-1:0]      w_sum;
  logic [c_v_w-1:0]        w_old;
  logic [c_v_w-1:0]        w_v;
  logic                    w_ovf;
  logic [c_dw-1:0]         w_elem;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_elem_done = (r_k == c_k_last);
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_calc) begin
          w_accept    = 1'b1;
          w_state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        w_step = 1'b1;
        if (w_elem_done && (r_row == c_r_last) && (r_col == c_c_last)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_a_idx  = int'(r_row) * c_k + int'(r_k);
    w_b_idx  = int'(r_k) * c_n + int'(r_col);
    w_c_idx  = int'(r_row) * c_n + int'(r_col);
    w_a_elem = r_a[w_a_idx*c_dw +: c_dw];
    w_b_elem = r_b[w_b_idx*c_dw +: c_dw];
    w_prod   = c_pw'(w_a_elem) * c_pw'(w_b_elem);
    w_sum    = r_acc + c_acc_w'(w_prod);
    // In accumulate mode the element being finished is still the previous C.
    w_old    = r_mode[1] ? c_v_w'(r_result[w_c_idx*c_dw +: c_dw]) : '0;
    w_v      = c_v_w'(w_sum) + w_old;
    w_ovf    = |w_v[c_v_w-1:c_dw];
    w_elem   = (w_ovf && r_mode[0]) ? {c_dw{1'b1}} : w_v[c_dw-1:0];
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_mode   <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_matrix_1;
      r_b     <= i_matrix_2;
      r_mode  <= i_mode;
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_ovf   <= 1'b0;
    end else if (w_step) begin
      if (w_elem_done) begin
        r_result[w_c_idx*c_dw +: c_dw] <= w_elem;
        if (w_ovf) begin
          r_ovf <= 1'b1;
        end
        r_acc <= '0;
        r_k   <= '0;
        if (r_col == c_c_last) begin
          r_col <= '0;
          r_row <= (r_row == c_r_last) ? '0 : r_row + c_rw'(1);
        end else begin
          r_col <= r_col + c_cw'(1);
        end
      end else begin
        r_acc <= w_sum;
        r_k   <= r_k + c_kw'(1);
      end
      if (w_last) begin
        r_ready <= 1'b1;
        r_busy  <= 1'b0;
      end
    end
  end

  assign o_result   = r_result;
  assign o_ready    = r_ready;
  assign o_busy     = r_busy;
  assign o_overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_matrix_mult_matrix_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_matrix_mult_matrix_seq
// Description : Self-checking bench for a 2x2x2/8-bit and a 3x4x2/16-bit instance.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_matrix_mult_matrix_seq;

  localparam int M0 = 2, K0 = 2, N0 = 2, D0 = 8;
  localparam int M1 = 3, K1 = 4, N1 = 2, D1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         calc0, calc1;
  logic [1:0]   mode0, mode1;
  logic [31:0]  a0, b0, res0;
  logic [191:0] a1;
  logic [127:0] b1;
  logic [95:0]  res1;
  logic         ready0, busy0, ovf0, ready1, busy1, ovf1;

  matrix_mult_matrix_seq #(
    .FIRST_MATRIX_HEIGHT(M0), .BOTH_MATRIX_W_H(K0),
    .SECOND_MATRIX_WIDTH(N0), .DATA_WIDTH(D0)
  ) u_dut0 (
    .clk(clk), .i_rst_n(rst_n), .i_calc(calc0), .i_mode(mode0),
    .i_matrix_1(a0), .i_matrix_2(b0), .o_result(res0),
    .o_ready(ready0), .o_busy(busy0), .o_overflow(ovf0)
  );

  matrix_mult_matrix_seq #(
    .FIRST_MATRIX_HEIGHT(M1), .BOTH_MATRIX_W_H(K1),
    .SECOND_MATRIX_WIDTH(N1), .DATA_WIDTH(D1)
  ) u_dut1 (
    .clk(clk), .i_rst_n(rst_n), .i_calc(calc1), .i_mode(mode1),
    .i_matrix_1(a1), .i_matrix_2(b1), .o_result(res1),
    .o_ready(ready1), .o_busy(busy1), .o_overflow(ovf1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [255:0] exp_c0, exp_c1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned elem(input logic [255:0] v, input int idx, input int dw);
    logic [255:0] t;
    t = v >> (idx * dw);
    return t[63:0] & ((64'd1 << dw) - 64'd1);
  endfunction

  // Returns {overflow, C} straight from the matrix-product definition.
  function automatic logic [256:0] ref_mult(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] c_old, input int m, input int k,
                                            input int n, input int dw, input logic [1:0] mode);
    logic [255:0]    res;
    logic            ovf;
    longint unsigned mask, s, v;
    res  = '0;
    ovf  = 1'b0;
    mask = (64'd1 << dw) - 64'd1;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        s = mode[1] ? elem(c_old, r*n + c, dw) : 64'd0;
        for (int kk = 0; kk < k; kk++)
          s += elem(a, r*k + kk, dw) * elem(b, kk*n + c, dw);
        if (s > mask) begin
          ovf = 1'b1;
          v   = mode[0] ? mask : (s & mask);
        end else begin
          v = s;
        end
        res |= 256'(v) << ((r*n + c) * dw);
      end
    end
    return {ovf, res};
  endfunction

  task automatic run(input int which, input logic [255:0] a, input logic [255:0] b,
                     input logic [1:0] mode, input bit pulse, input string tag);
    int           lat, cycles;
    bit           done;
    logic [256:0] exp;
    lat = (which != 0) ? M1*N1*K1 : M0*N0*K0;
    exp = (which != 0) ? ref_mult(a, b, exp_c1, M1, K1, N1, D1, mode)
                       : ref_mult(a, b, exp_c0, M0, K0, N0, D0, mode);
    @(negedge clk);
    if (which == 0) begin
      a0 = a[31:0]; b0 = b[31:0]; mode0 = mode; calc0 = 1'b1;
    end else begin
      a1 = a[191:0]; b1 = b[127:0]; mode1 = mode; calc1 = 1'b1;
    end
    @(posedge clk); #1;
    calc0 = 1'b0; calc1 = 1'b0;
    check({tag, "_busy_set"}, (which != 0) ? busy1 : busy0, 256'd1);
    check({tag, "_ready_clr"}, (which != 0) ? ready1 : ready0, 256'd0);
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < lat + 20) begin
      // Start requests and operand changes while busy must have no effect.
      if (pulse && (cycles == 2 || cycles == 5)) begin
        calc0 = 1'b1; a0 = $urandom; b0 = $urandom; mode0 = ~mode0;
      end
      @(posedge clk); #1;
      cycles++;
      calc0 = 1'b0;
      done  = (which != 0) ? ready1 : ready0;
    end
    check({tag, "_latency"}, 256'(cycles), 256'(lat));
    if (which == 0) begin
      check({tag, "_result"}, 256'(res0), exp[255:0]);
      check({tag, "_ovf"}, 256'(ovf0), 256'(exp[256]));
      check({tag, "_busy_clr"}, 256'(busy0), 256'd0);
      exp_c0 = exp[255:0];
    end else begin
      check({tag, "_result"}, 256'(res1), exp[255:0]);
      check({tag, "_ovf"}, 256'(ovf1), 256'(exp[256]));
      check({tag, "_busy_clr"}, 256'(busy1), 256'd0);
      exp_c1 = exp[255:0];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] ra, rb;
    rst_n = 1'b0;
    calc0 = 1'b0; calc1 = 1'b0; mode0 = 2'b00; mode1 = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    exp_c0 = '0; exp_c1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 256'(res0), 256'd0);
    check("rst_ready", 256'(ready0), 256'd0);
    check("rst_busy", 256'(busy0), 256'd0);
    check("rst_ovf", 256'(ovf0), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 256'h01020304, 256'h05060708, 2'b00, 1'b0, "basic");
    check("basic_const", 256'(res0), 256'h13162B32);
    run(0, 256'h01020304, 256'h05060708, 2'b10, 1'b0, "accum");
    check("accum_const", 256'(res0), 256'h262C5664);
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold", 256'(res0), 256'h262C5664);
    check("idle_ready_hold", 256'(ready0), 256'd1);

    run(0, 256'hC8C8C8C8, 256'hC8C8C8C8, 2'b01, 1'b0, "sat");
    check("sat_const", 256'(res0), 256'hFFFFFFFF);
    check("sat_ovf_const", 256'(ovf0), 256'd1);
    run(0, 256'hC8C8C8C8, 256'hC8C8C8C8, 2'b00, 1'b0, "wrap");
    check("wrap_const", 256'(res0), 256'h80808080);
    check("wrap_ovf_const", 256'(ovf0), 256'd1);

    run(0, 256'h01020304, 256'h05060708, 2'b00, 1'b1, "busy_ign");
    check("busy_ign_const", 256'(res0), 256'h13162B32);
    run(0, 256'h01020304, 256'h05060708, 2'b10, 1'b0, "b2b");
    check("b2b_const", 256'(res0), 256'h262C5664);

    // Reset lands on the fourth MAC edge of an accumulate run.
    @(negedge clk);
    a0 = 32'h01020304; b0 = 32'h05060708; mode0 = 2'b10; calc0 = 1'b1;
    @(posedge clk); #1;
    calc0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_result", 256'(res0), 256'd0);
    check("midrst_ready", 256'(ready0), 256'd0);
    check("midrst_busy", 256'(busy0), 256'd0);
    check("midrst_ovf", 256'(ovf0), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_c0 = '0; exp_c1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_idle", 256'(busy0), 256'd0);
    run(0, 256'h01020304, 256'h05060708, 2'b10, 1'b0, "post_rst");
    check("post_rst_const", 256'(res0), 256'h13162B32);

    for (int i = 0; i < 4; i++) begin
      ra = 256'($urandom);
      rb = 256'($urandom);
      run(0, ra, rb, 2'($urandom_range(0, 3)), 1'b0, "rand0");
    end

    for (int i = 0; i < 8; i++) begin
      ra = '0;
      rb = '0;
      for (int e = 0; e < M1*K1; e++)
        ra[e*D1 +: D1] = 16'((i % 2 == 1) ? $urandom_range(0, 15) : $urandom_range(0, 65535));
      for (int e = 0; e < K1*N1; e++)
        rb[e*D1 +: D1] = 16'((i % 2 == 1) ? $urandom_range(0, 15) : $urandom_range(0, 65535));
      run(1, ra, rb, 2'($urandom_range(0, 3)), 1'b0, "rand1");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_mult_matrix_seq.md
# matrix_mult_matrix_seq

Parametrised, resource-shared successor to the combinational-style matrix multiplier. It computes C = A×B, or C = C + A×B, for unsigned M×K by K×N matrices using a single multiply-accumulate unit stepped over every (row, col, k) triple. It adds a saturate/wrap output mode, an accumulate mode, an overflow flag and a busy/ready handshake. It sits in the matrix datapath wherever area matters more than latency.

## Interface
- FIRST_MATRIX_HEIGHT, 2, M: rows of A and C.
- BOTH_MATRIX_W_H, 2, K: columns of A and rows of B.
- SECOND_MATRIX_WIDTH, 2, N: columns of B and C.
- DATA_WIDTH, 8, DW: width of every element of A, B and C.
- clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_calc  in  1  start request; sampled only in IDLE.
- i_mode  in  2  bit0: 1 saturate, 0 wrap. bit1: 1 accumulate onto current o_result, 0 overwrite. Latched on accept.
- i_matrix_1  in  M*K*DW  A; element (r,c) at flat index r*K+c, bits [idx*DW +: DW].
- i_matrix_2  in  K*N*DW  B; same packing with row length N.
- o_result  out  M*N*DW  C; same packing with row length N.
- o_ready  out  1  result valid; cleared when a new computation is accepted.
- o_busy  out  1  computation in progress.
- o_overflow  out  1  at least one element of the last result exceeded 2^DW-1 before clamp/wrap.

## Operation
- States: IDLE and MAC.
- **IDLE, i_calc=1 at edge:**
  - Latch A, B and i_mode.
  - Clear r, c, k and the accumulator.
  - Clear o_overflow and o_ready; set o_busy; go to MAC.
- **IDLE, i_calc=0:** hold all outputs.
- **MAC, each edge:**
  - acc += A[r][k]*B[k][c], full precision.
  - Accumulator width is 2*DW+clog2(K)+1, so no internal overflow is possible.
- **MAC, when k==K-1:** the element value is v = sum, or v = old C[r][c] + sum if accumulate mode is set.
  - If v > 2^DW-1: set o_overflow (sticky for this computation). Write 2^DW-1 if saturating, else v[DW-1:0].
  - Otherwise write v.
  - Clear acc and k, then advance c; wrap c to 0 and advance r.
- **Last write (r==M-1, c==N-1, k==K-1):** go to IDLE, set o_ready, clear o_busy.
- **Step order:** k is innermost, then c, then r.
- **In-place update:** o_result is updated element by element while busy and is valid only while o_ready=1. Each element is read (for accumulate) and written exactly once per computation, so in-place update is correct.
- i_calc while busy is ignored, not queued.
- Input operands may change after the accept edge without effect.
- All arithmetic is unsigned.

## Timing
- Reset (i_rst_n=0 at an edge, any state, including mid-computation):
  - o_result=0, o_ready=0, o_busy=0, o_overflow=0.
  - State IDLE; counters and accumulator cleared.
  - Reset takes priority over i_calc in the same cycle.
- Accept at edge E0. MAC steps occur at edges E0+1 … E0+P, with P = M*N*K.
- At E0+P the final element is written, o_ready=1 and o_busy=0; latency P cycles. For 2×2×2: 8 cycles.
- Element (r,c) is written at edge E0+(r*N+c+1)*K.
- A new i_calc is accepted no earlier than edge E0+P+1, i.e. the first edge at which o_ready is seen high.
- o_ready and o_overflow hold until the next accept or reset.
- Accumulate mode after reset accumulates onto 0, which is the same as overwrite.
- Degenerate K=1: each element is written on the cycle of its single product.

## Test plan
- **Basic product.** Reset, then A={1,2,3,4}, B={5,6,7,8} (MSB-first concatenation, i.e. A rows [4,3],[2,1]; B rows [8,7],[6,5]), mode=00, 1-cycle i_calc → o_ready high exactly 8 cycles after the accept edge. o_result=0x13162B32 (elements 50,43,22,19), o_overflow=0.
- **Accumulate.** Repeat with mode=10 → o_result=0x262C5664 (100,86,44,38), o_overflow=0.
- **Overflow.** All A and B elements 200, K=2 → mode=01 gives every element 0xFF; mode=00 gives every element 0x80. o_overflow=1 in both cases.
- **Busy-period start ignored.** Pulse i_calc at cycles 3 and 6 after the accept → only one computation. o_ready still rises at +8 with unchanged results; back-to-back accept succeeds on the edge after o_ready rises.
- **Reset mid-computation.** Assert i_rst_n=0 at cycle 4 of MAC → next edge all outputs 0, state IDLE. A fresh i_calc then yields the basic-product result after 8 cycles.
- **Non-square parameters.** M=3, K=4, N=2, DW=16 with random operands against a reference model → latency 24 cycles, all elements match, o_overflow matches the model.
